// File: rtl/cpu_clk_pkg.sv
// Shared types and default sizing for the CPU phase generator.
package cpu_clk_pkg;

    // Sequencer states: idle, free-running, or executing one stepped cycle
    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    localparam int DEF_NUM_PHASES = 4;
    localparam int DEF_DIV_W      = 8;
    localparam int DEF_CNT_W      = 32;

endpackage

// File: rtl/clk_prescaler.sv
// Prescaler: counts 0..div and flags the terminal count with a registered tick.
// The tick is computed from the counter's next value, so during any clk it is
// high exactly when cnt equals the divide value that is in force for that clk.
module clk_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick,
    output logic [DIV_W-1:0] cnt
);

    logic [DIV_W-1:0] cnt_next;

    // Next count: clear, wrap after the terminal count, or advance
    always_comb begin
        cnt_next = cnt;
        if (clr) begin
            cnt_next = '0;
        end else if (en) begin
            cnt_next = tick ? '0 : cnt + DIV_W'(1);
        end
    end

    // Counter and registered terminal-count flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            tick <= (cnt_next == div);
        end
    end

endmodule

// File: rtl/cpu_phase_gen.sv
// CPU phase generator: derives NUM_PHASES one-hot phase strobes per CPU cycle
// from a single clock, with run/halt, single-step handshake and cycle counter.
// Internal state leads the registered outputs by exactly one clk.
module cpu_phase_gen
    import cpu_clk_pkg::*;
#(
    parameter int NUM_PHASES = DEF_NUM_PHASES,
    parameter int DIV_W      = DEF_DIV_W,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  step_req,
    output logic                  step_ack,
    input  logic [DIV_W-1:0]      div_in,
    output logic [NUM_PHASES-1:0] phase_stb,
    output logic [NUM_PHASES-1:0] phase_lvl,
    output logic                  cycle_end,
    output logic                  running,
    output logic [CNT_W-1:0]      cycle_cnt
);

    localparam int PH_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
    localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(NUM_PHASES - 1);

    state_t                  state;
    state_t                  next_state;
    logic [PH_W-1:0]         phase_cnt;
    logic [DIV_W-1:0]        div_q;
    logic [DIV_W-1:0]        div_d;
    logic [DIV_W-1:0]        pre_cnt;
    logic                    pre_tick;
    logic                    step_armed;
    logic                    last_clk;
    logic                    cycle_start;
    logic                    active;
    logic [NUM_PHASES-1:0]   phase_onehot;
    logic [NUM_PHASES-1:0]   stb_d;
    logic [NUM_PHASES-1:0]   lvl_d;
    logic                    cycle_end_d;
    logic                    step_ack_d;
    logic                    running_d;

    assign active       = (state != HALT);
    assign last_clk     = active && pre_tick && (phase_cnt == LAST_PHASE);
    assign cycle_start  = ((state == HALT) && (next_state != HALT)) ||
                          ((state == RUN) && last_clk && run);
    assign div_d        = cycle_start ? div_in : div_q;
    assign phase_onehot = NUM_PHASES'(1) << phase_cnt;

    clk_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == HALT),
        .en   (active),
        .div  (div_d),
        .tick (pre_tick),
        .cnt  (pre_cnt)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= HALT;
        end else begin
            state <= next_state;
        end
    end

    // Next state: run beats step, cycles only ever end on their last clk
    always_comb begin
        next_state = state;
        case (state)
            HALT: begin
                if (run) begin
                    next_state = RUN;
                end else if (step_req && step_armed) begin
                    next_state = STEP;
                end
            end
            RUN: begin
                if (last_clk && !run) begin
                    next_state = HALT;
                end
            end
            STEP: begin
                if (last_clk) begin
                    next_state = HALT;
                end
            end
            default: next_state = HALT;
        endcase
    end

    // Output decode of the internal state, registered one clk later below
    always_comb begin
        stb_d       = '0;
        lvl_d       = '0;
        cycle_end_d = 1'b0;
        step_ack_d  = 1'b0;
        running_d   = 1'b0;
        if (active) begin
            lvl_d       = phase_onehot;
            running_d   = 1'b1;
            cycle_end_d = last_clk;
            step_ack_d  = last_clk && (state == STEP);
            if (pre_cnt == '0) begin
                stb_d = phase_onehot;
            end
        end
    end

    // Phase counter, divide latch and step handshake arming
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_cnt  <= '0;
            div_q      <= '0;
            step_armed <= 1'b1;
        end else begin
            div_q <= div_d;
            if (!active) begin
                phase_cnt <= '0;
            end else if (pre_tick) begin
                phase_cnt <= (phase_cnt == LAST_PHASE) ? '0 : phase_cnt + PH_W'(1);
            end
            if (state == HALT) begin
                if (!step_req) begin
                    step_armed <= 1'b1;
                end else if (next_state == STEP) begin
                    step_armed <= 1'b0;
                end
            end
        end
    end

    // Registered outputs and completed-cycle counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_stb <= '0;
            phase_lvl <= '0;
            cycle_end <= 1'b0;
            step_ack  <= 1'b0;
            running   <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            phase_stb <= stb_d;
            phase_lvl <= lvl_d;
            cycle_end <= cycle_end_d;
            step_ack  <= step_ack_d;
            running   <= running_d;
            if (cycle_end) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cpu_phase_gen.sv
// Scoreboard testbench for cpu_phase_gen (NUM_PHASES=4, DIV_W=8, CNT_W=32).
module tb_cpu_phase_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        step_req;
    logic        step_ack;
    logic [7:0]  div_in;
    logic [3:0]  phase_stb;
    logic [3:0]  phase_lvl;
    logic        cycle_end;
    logic        running;
    logic [31:0] cycle_cnt;

    typedef struct packed {
        logic [3:0]  stb;
        logic [3:0]  lvl;
        logic        ce;
        logic        ack;
        logic        running;
        logic [31:0] cnt;
        logic [15:0] gap;
    } evt_t;

    evt_t expQ[$];
    int   checkCount = 0;
    int   passCount  = 0;
    int   clkCnt     = 0;
    int   lastEvt    = 0;

    cpu_phase_gen dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .step_req  (step_req),
        .step_ack  (step_ack),
        .div_in    (div_in),
        .phase_stb (phase_stb),
        .phase_lvl (phase_lvl),
        .cycle_end (cycle_end),
        .running   (running),
        .cycle_cnt (cycle_cnt)
    );

    // 10-unit clock period
    always #5 clk = ~clk;

    // Free-running clk counter used to measure gaps between output events
    always @(posedge clk) clkCnt <= clkCnt + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic void pushEvt(input logic [3:0] stb, input logic [3:0] lvl, input logic ce,
                                    input logic ack, input int cnt, input int gap);
        evt_t e;
        e.stb     = stb;
        e.lvl     = lvl;
        e.ce      = ce;
        e.ack     = ack;
        e.running = 1'b1;
        e.cnt     = 32'(cnt);
        e.gap     = 16'(gap);
        expQ.push_back(e);
    endfunction

    // One CPU cycle of divide d: four phase strobes, plus a separate end event when phases last >1 clk
    function automatic void pushCycle(input int d, input int cntBefore, input int firstGap, input bit step);
        for (int k = 0; k < 4; k++) begin
            pushEvt(4'(1 << k), 4'(1 << k), (d == 0) && (k == 3), (d == 0) && (k == 3) && step,
                    cntBefore, (k == 0) ? firstGap : d + 1);
        end
        if (d > 0) begin
            pushEvt(4'b0000, 4'b1000, 1'b1, step, cntBefore, d);
        end
    endfunction

    task automatic tickClk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic [7:0] d, input bit markStart);
        run      = r;
        step_req = s;
        div_in   = d;
        if (markStart) begin
            lastEvt = clkCnt;
        end
    endtask

    // Monitor: every clk with a strobe, cycle end or ack is matched against the scoreboard
    always @(negedge clk) begin
        evt_t act;
        evt_t expd;
        if ((phase_stb != 4'b0000) || cycle_end || step_ack) begin
            act.stb     = phase_stb;
            act.lvl     = phase_lvl;
            act.ce      = cycle_end;
            act.ack     = step_ack;
            act.running = running;
            act.cnt     = cycle_cnt;
            act.gap     = 16'(clkCnt - lastEvt);
            lastEvt     = clkCnt;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_evt", 64'(act), 64'd0);
            end else begin
                expd = expQ.pop_front();
                checkOutput("evt", 64'(act), 64'(expd));
            end
        end
    end

    // Watchdog so the run can never hang
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
        #1 rst = 1'b0;
        tickClk(2);
        checkOutput("rst_stb", 64'(phase_stb), 64'd0);
        checkOutput("rst_lvl", 64'(phase_lvl), 64'd0);
        checkOutput("rst_running", 64'(running), 64'd0);
        checkOutput("rst_cycle_end", 64'(cycle_end), 64'd0);
        checkOutput("rst_step_ack", 64'(step_ack), 64'd0);
        checkOutput("rst_cycle_cnt", 64'(cycle_cnt), 64'd0);
        rst = 1'b1;
        tickClk(2);

        $display("[TB] free-run div=0");
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b1);
        pushCycle(0, 0, 2, 1'b0);
        for (int c = 1; c < 5; c++) pushCycle(0, c, 1, 1'b0);
        tickClk(20);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
        tickClk(4);
        checkOutput("div0_cycle_cnt", 64'(cycle_cnt), 64'd5);
        checkOutput("div0_running", 64'(running), 64'd0);
        checkOutput("div0_queue", 64'(expQ.size()), 64'd0);

        $display("[TB] free-run div=2");
        applyStimulus(1'b1, 1'b0, 8'd2, 1'b1);
        pushCycle(2, 5, 2, 1'b0);
        pushCycle(2, 6, 1, 1'b0);
        tickClk(24);
        applyStimulus(1'b0, 1'b0, 8'd2, 1'b0);
        tickClk(4);
        checkOutput("div2_cycle_cnt", 64'(cycle_cnt), 64'd7);
        checkOutput("div2_queue", 64'(expQ.size()), 64'd0);

        $display("[TB] halt mid-cycle");
        applyStimulus(1'b1, 1'b0, 8'd1, 1'b1);
        pushCycle(1, 7, 2, 1'b0);
        tickClk(3);
        applyStimulus(1'b0, 1'b0, 8'd1, 1'b0);
        tickClk(8);
        checkOutput("halt_cycle_cnt", 64'(cycle_cnt), 64'd8);
        checkOutput("halt_running", 64'(running), 64'd0);
        checkOutput("halt_lvl", 64'(phase_lvl), 64'd0);
        checkOutput("halt_queue", 64'(expQ.size()), 64'd0);

        $display("[TB] single step");
        applyStimulus(1'b0, 1'b1, 8'd1, 1'b1);
        pushCycle(1, 8, 2, 1'b1);
        tickClk(10);
        applyStimulus(1'b0, 1'b0, 8'd1, 1'b0);
        tickClk(6);
        checkOutput("step1_cycle_cnt", 64'(cycle_cnt), 64'd9);
        checkOutput("step1_queue", 64'(expQ.size()), 64'd0);
        applyStimulus(1'b0, 1'b1, 8'd1, 1'b1);
        pushCycle(1, 9, 2, 1'b1);
        tickClk(10);
        applyStimulus(1'b0, 1'b0, 8'd1, 1'b0);
        tickClk(4);
        checkOutput("step2_cycle_cnt", 64'(cycle_cnt), 64'd10);
        checkOutput("step2_queue", 64'(expQ.size()), 64'd0);

        $display("[TB] divide change mid-cycle");
        applyStimulus(1'b1, 1'b0, 8'd1, 1'b1);
        pushCycle(1, 10, 2, 1'b0);
        pushCycle(3, 11, 1, 1'b0);
        tickClk(3);
        applyStimulus(1'b1, 1'b0, 8'd3, 1'b0);
        tickClk(21);
        applyStimulus(1'b0, 1'b0, 8'd3, 1'b0);
        tickClk(4);
        checkOutput("divchg_cycle_cnt", 64'(cycle_cnt), 64'd12);
        checkOutput("divchg_queue", 64'(expQ.size()), 64'd0);

        $display("[TB] run and step together");
        applyStimulus(1'b1, 1'b1, 8'd0, 1'b1);
        pushCycle(0, 12, 2, 1'b0);
        pushCycle(0, 13, 1, 1'b0);
        tickClk(8);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
        tickClk(4);
        checkOutput("both_cycle_cnt", 64'(cycle_cnt), 64'd14);
        checkOutput("both_queue", 64'(expQ.size()), 64'd0);

        $display("[TB] reset mid-run");
        applyStimulus(1'b1, 1'b0, 8'd1, 1'b1);
        pushEvt(4'b0001, 4'b0001, 1'b0, 1'b0, 14, 2);
        pushEvt(4'b0010, 4'b0010, 1'b0, 1'b0, 14, 2);
        pushEvt(4'b0100, 4'b0100, 1'b0, 1'b0, 14, 2);
        tickClk(6);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        checkOutput("arst_stb", 64'(phase_stb), 64'd0);
        checkOutput("arst_lvl", 64'(phase_lvl), 64'd0);
        checkOutput("arst_running", 64'(running), 64'd0);
        checkOutput("arst_cycle_cnt", 64'(cycle_cnt), 64'd0);
        checkOutput("arst_queue", 64'(expQ.size()), 64'd0);
        tickClk(2);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'd1, 1'b1);
        pushCycle(1, 0, 2, 1'b0);
        tickClk(8);
        applyStimulus(1'b0, 1'b0, 8'd1, 1'b0);
        tickClk(4);
        checkOutput("restart_cycle_cnt", 64'(cycle_cnt), 64'd1);
        checkOutput("restart_queue", 64'(expQ.size()), 64'd0);

        tickClk(2);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/cpu_phase_gen.md
Name: cpu_phase_gen

Overview:
- Parametrised, all-logic successor to the CPU clock block. Instead of combining two PLL phases, it derives NUM_PHASES phase strobes per CPU cycle from a single clock using a programmable prescaler.
- Adds run/halt control, a single-step handshake, divide-ratio update at cycle boundaries and a CPU cycle counter.
- Sits between the board clock and the CPU datapath; its strobes are used as clock enables, never as clocks.

Parameters:
- NUM_PHASES, 4, phases per CPU cycle (>=2).
- DIV_W, 8, width of the prescaler divide field.
- CNT_W, 32, width of the CPU cycle counter.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = free-run CPU cycles.
- step_req  in  1  level request for exactly one CPU cycle while halted.
- step_ack  out  1  one-clk pulse when the stepped cycle completes.
- div_in  in  DIV_W  each phase lasts div_in+1 clk cycles.
- phase_stb  out  NUM_PHASES  one-hot, one-clk pulse on the first clk of phase k.
- phase_lvl  out  NUM_PHASES  one-hot, high for the whole of phase k.
- cycle_end  out  1  one-clk pulse on the last clk of the last phase.
- running  out  1  high while a CPU cycle is in progress.
- cycle_cnt  out  CNT_W  completed CPU cycles.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to HALT.
  - All outputs go to 0, including cycle_cnt.
  - Internal counters go to 0 and div_q goes to 0.
  - Reset asserted mid-cycle aborts the cycle immediately. There is no ack and no cycle_end.
- All outputs are registered.
- State machine, states HALT, RUN, STEP:
  - HALT, run=1 sampled at edge n: go to RUN. phase_stb[0] and running are high in the clk cycle after edge n+1, i.e. one clk of latency.
  - HALT, run=0 and step_req=1: go to STEP with the same one-clk latency.
  - HALT, run=1 and step_req=1 together: run wins. The step is not counted and no step_ack is produced.
  - RUN: at every cycle_end, if run=0 go to HALT, otherwise start the next cycle back-to-back with no gap clk.
  - RUN, run dropping mid-cycle: the current cycle completes all remaining phases first. A cycle is never truncated.
  - STEP: runs exactly one CPU cycle, then goes to HALT. step_ack pulses in the same clk as cycle_end.
  - STEP, step_req still high at ack: no new step starts. step_req must be sampled low in HALT before the next step is accepted (4-phase handshake).
  - step_req while in RUN is ignored.
- Timing:
  - div_q is latched from div_in on the first clk of each CPU cycle. Changing div_in mid-cycle affects only the next cycle.
  - Prescaler: pre_cnt counts 0..div_q. When pre_cnt==div_q, phase_cnt advances and pre_cnt clears.
  - phase_cnt runs 0..NUM_PHASES-1 and wraps to 0 after the last phase.
  - div_in=0 gives one clk per phase.
  - CPU cycle length is NUM_PHASES*(div_q+1) clk.
- Outputs:
  - phase_lvl is one-hot while running and all-zero in HALT.
  - phase_stb[k] is asserted only when phase_lvl[k] is high and pre_cnt==0.
  - cycle_cnt increments by 1 in the clk after each cycle_end. It wraps modulo 2^CNT_W without saturating.
  - running falls in the clk after the final cycle_end.

Decomposition:
- Package cpu_clk_pkg:
  - state enum {HALT, RUN, STEP}.
  - Default parameter constants.
- Sub-module clk_prescaler:
  - Parameter DIV_W.
  - Inputs clk, rst, clr, en, div.
  - Outputs tick (registered terminal count) and cnt.
  - Instantiated once; the top level holds the FSM, the phase counter and the cycle counter.

Test Plan:
- Free-run, div=0: reset, div_in=0, run=1 -> phase_stb cycles 0001,0010,0100,1000 with a period of 4 clk; cycle_end every 4th clk; cycle_cnt=5 after 20 clk of running.
- Free-run, div=2: div_in=2, run=1 -> each phase_lvl is high for 3 clk and a cycle lasts 12 clk; phase_stb[k] is exactly 1 clk, on the first clk of phase k.
- Halt mid-cycle: run dropped during phase 1 -> phases 2 and 3 complete, one cycle_end, then running=0 and phase_lvl=0000; cycle_cnt is 1 higher than at the drop.
- Single step: in HALT, step_req held high for 10 clk with div_in=1 -> exactly one 8-clk cycle, step_ack single pulse coincident with cycle_end, cycle_cnt+1; no second cycle until step_req has been seen low and then high again.
- Div change and simultaneous requests:
  - div_in changed 1->3 mid-cycle -> the current cycle keeps 2-clk phases and the next cycle uses 4-clk phases.
  - run and step_req raised together -> RUN is entered and step_ack is never asserted.
- Reset mid-run: rst low during phase 2 -> all outputs are 0 within the same clk (asynchronous); after rst is released with run=1, the cycle restarts from phase 0 and cycle_cnt restarts from 0.
